mmcm_ps_step_sequencer: RTL
===========================

// Module: mmcm_ps_step_sequencer
// PURPOSE
//  Sequences MMCM dynamic phase-shift (psen/psincdec/psdone) on the psclk domain. The servo loop
//  requests a signed step count; this block issues one psen pulse per step and waits for psdone.
//  It enforces a minimum psen spacing, times out a missing psdone, tracks the cumulative phase
//  position and supports abort. It replaces free-running psen pacing in the MMCM slave servo.
// PARAMETERS
//  STEP_W   16   width of signed step request; magnitude up to 2**(STEP_W-1)
//  POS_W    32   width of signed cumulative phase position
//  MIN_GAP  13   idle psclk cycles between psdone and next psen (0 = back-to-back)
//  TIMEOUT  64   psclk cycles allowed from psen to psdone before error
// PORTS
//  psclk          in   1       phase-shift clock; all logic on rising edge
//  reset_n        in   1       synchronous, active-low reset
//  req_valid      in   1       step request valid
//  req_ready      out  1       request accepted when req_valid & req_ready
//  req_steps      in   STEP_W  signed steps; >0 = increment, <0 = decrement
//  abort          in   1       cancel remaining steps of current request
//  mmcm_locked    in   1       MMCM lock; low forces immediate termination
//  psen           out  1       to MMCM PSEN, single-cycle pulse
//  psincdec       out  1       to MMCM PSINCDEC, 1 = increment
//  psdone         in   1       from MMCM PSDONE
//  busy           out  1       request in progress (state != IDLE)
//  steps_left     out  STEP_W  unsigned steps still to issue
//  done_pulse     out  1       one-cycle completion strobe
//  done_status    out  2       valid with done_pulse: 0 OK, 1 ABORT, 2 TIMEOUT, 3 LOCK_LOST
//  pos_clear      in   1       zero phase_pos
//  phase_pos      out  POS_W   signed cumulative completed steps (+1 inc, -1 dec)
// BEHAVIOUR
//  Reset (reset_n=0 at edge): state IDLE; psen, psincdec, busy, done_pulse = 0; done_status = 0;
//   steps_left = 0; phase_pos = 0. Reset mid-step abandons the step and emits no done_pulse.
//  req_ready = (state==IDLE) & mmcm_locked & reset_n (combinational from registered state).
//  FSM IDLE -> ISSUE -> WAIT_DONE -> (GAP -> ISSUE)* -> IDLE.
//  IDLE: on accept, latch |req_steps| (zero-extended to STEP_W unsigned; most-negative value is
//   legal, giving 2**(STEP_W-1)) and psincdec = ~req_steps[MSB]. If req_steps==0, stay in IDLE
//   and assert done_pulse OK on the next cycle with no psen.
//  ISSUE: psen=1 for exactly this one cycle (the cycle after accept or after GAP ends), then WAIT_DONE.
//  psincdec is registered. It changes only on accept and is stable from ISSUE through last psdone.
//  WAIT_DONE: timer counts from 0.
//   - psdone: phase_pos += (psincdec ? +1 : -1), steps_left -= 1.
//     If steps_left becomes 0 -> done OK, IDLE. Else if abort is pending -> done ABORT, IDLE.
//     Else if MIN_GAP==0 -> ISSUE. Else -> GAP.
//   - timer reaches TIMEOUT-1 without psdone -> done TIMEOUT, IDLE, steps_left cleared.
//     A later stray psdone is ignored in IDLE.
//   - abort in WAIT_DONE is latched. The in-flight step still completes and is counted.
//  GAP: count MIN_GAP cycles, then ISSUE. Abort in GAP -> done ABORT next cycle, IDLE.
//  abort in ISSUE: psen still fires; handled as pending abort in WAIT_DONE.
//   abort in IDLE has no effect.
//  mmcm_locked=0 in any non-IDLE state: next cycle IDLE, done LOCK_LOST, no phase_pos update,
//   psen forced 0. Lock loss has priority over psdone, timeout and abort in the same cycle.
//  done_pulse asserts in the cycle after the terminating event and lasts one cycle.
//   done_status holds its value until the next done_pulse.
//  pos_clear priority: phase_pos <= 0 + delta, where delta is this cycle's psdone contribution
//   (0 if none). phase_pos wraps modulo 2**POS_W (no saturation).
//  Total latency per step = 1 (psen) + psdone latency + MIN_GAP cycles.
// STRUCTURE
//  mmcm_ps_pkg: typedef enum ps_state_t {IDLE, ISSUE, WAIT_DONE, GAP};
//   typedef enum ps_status_t {PS_OK, PS_ABORT, PS_TIMEOUT, PS_LOCK_LOST}.
//  Sub-module mmcm_ps_timer: loadable up-counter with terminal-count compare, shared by the GAP
//   wait and the WAIT_DONE timeout (only one is active at a time).
// TESTING
//  1 req_steps=+5, MIN_GAP=13, psdone 3 cycles after each psen -> 5 psen pulses with psincdec=1,
//    psen pulses 17 cycles apart; phase_pos=+5; done OK.
//  2 req_steps=-3 after test 1 -> psincdec=0 throughout, phase_pos=+2, done OK; req_steps=0 ->
//    no psen, done OK 1 cycle after accept.
//  3 req_steps=+10, abort asserted in WAIT_DONE of step 4 -> step 4 completes, phase_pos +4,
//    steps_left=6, done ABORT, no further psen.
//  4 psdone withheld -> done TIMEOUT 64 cycles after psen; late psdone ignored; phase_pos unchanged.
//  5 mmcm_locked dropped same cycle as psdone mid-request -> done LOCK_LOST, phase_pos not
//    updated, req_ready=0 until relock.
//  6 STEP_W=16, req_steps=-32768 accepted -> steps_left=32768; pos_clear together with a dec
//    psdone -> phase_pos=-1; reset_n=0 mid-request -> all outputs at reset values, no done_pulse.

Source files
------------

// File: rtl/mmcm_ps_pkg.sv
// Shared types for the MMCM phase-shift step sequencer.
package mmcm_ps_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } ps_state_t;

  typedef enum logic [1:0] {
    PS_OK,
    PS_ABORT,
    PS_TIMEOUT,
    PS_LOCK_LOST
  } ps_status_t;

endpackage

// File: rtl/mmcm_ps_timer.sv
// Up-counter with terminal-count compare. One instance serves both the
// post-psdone spacing wait and the psdone timeout, since only one of them
// is ever running. Holding clear keeps it parked at zero.
module mmcm_ps_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clear,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] count;

  // Count up every cycle unless parked by clear.
  always_ff @(posedge clk) begin
    if (!reset_n)   count <= '0;
    else if (clear) count <= '0;
    else            count <= count + W'(1);
  end

  assign tc = (count == term);

endmodule

// File: rtl/mmcm_ps_step_sequencer.sv
// Issues one MMCM psen pulse per requested phase step, waits for psdone,
// spaces steps by MIN_GAP idle cycles, times out a missing psdone, and
// keeps a running signed phase position.
module mmcm_ps_step_sequencer
  import mmcm_ps_pkg::*;
#(
  parameter int STEP_W  = 16,
  parameter int POS_W   = 32,
  parameter int MIN_GAP = 13,
  parameter int TIMEOUT = 64
) (
  input  logic                     psclk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic signed [STEP_W-1:0] req_steps,
  input  logic                     abort,
  input  logic                     mmcm_locked,
  output logic                     psen,
  output logic                     psincdec,
  input  logic                     psdone,
  output logic                     busy,
  output logic [STEP_W-1:0]        steps_left,
  output logic                     done_pulse,
  output logic [1:0]               done_status,
  input  logic                     pos_clear,
  output logic signed [POS_W-1:0]  phase_pos
);

  // Timer must reach the larger of the two terminal counts.
  localparam int TMAX   = (TIMEOUT > MIN_GAP) ? TIMEOUT : MIN_GAP;
  localparam int TMR_W  = (TMAX > 2) ? $clog2(TMAX) : 1;
  localparam int GAP_TC = (MIN_GAP > 0) ? MIN_GAP - 1 : 0;
  localparam int TO_TC  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  ps_state_t         state;
  logic              abort_pend;
  logic [STEP_W-1:0] req_mag;
  logic [STEP_W-1:0] steps_dec;
  logic              step_done;
  logic              tmr_clear;
  logic [TMR_W-1:0]  tmr_term;
  logic              tmr_tc;

  // Most-negative request maps to 2**(STEP_W-1), which fits unsigned.
  assign req_mag   = req_steps[STEP_W-1] ? STEP_W'(-req_steps) : STEP_W'(req_steps);
  assign steps_dec = steps_left - STEP_W'(1);
  assign req_ready = (state == IDLE) & mmcm_locked & reset_n;
  assign busy      = (state != IDLE);

  // A step only counts if the MMCM is still locked when psdone arrives.
  assign step_done = (state == WAIT_DONE) & psdone & mmcm_locked;

  // Timer runs only in WAIT_DONE/GAP; a psdone restarts it for the gap wait.
  assign tmr_clear = !((state == WAIT_DONE) || (state == GAP)) ||
                     ((state == WAIT_DONE) && psdone);
  assign tmr_term  = (state == GAP) ? TMR_W'(GAP_TC) : TMR_W'(TO_TC);

  mmcm_ps_timer #(.W(TMR_W)) u_timer (
    .clk     (psclk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .term    (tmr_term),
    .tc      (tmr_tc)
  );

  // Step sequencing FSM with registered psen/done outputs.
  always_ff @(posedge psclk) begin
    if (!reset_n) begin
      state       <= IDLE;
      psen        <= 1'b0;
      psincdec    <= 1'b0;
      done_pulse  <= 1'b0;
      done_status <= PS_OK;
      steps_left  <= '0;
      abort_pend  <= 1'b0;
    end else begin
      psen       <= 1'b0;
      done_pulse <= 1'b0;
      if (state != IDLE && !mmcm_locked) begin
        // Lock loss overrides psdone, timeout and abort.
        state       <= IDLE;
        abort_pend  <= 1'b0;
        done_pulse  <= 1'b1;
        done_status <= PS_LOCK_LOST;
      end else begin
        case (state)
          IDLE: begin
            abort_pend <= 1'b0;
            if (req_valid && req_ready) begin
              psincdec   <= ~req_steps[STEP_W-1];
              steps_left <= req_mag;
              if (req_steps == '0) begin
                done_pulse  <= 1'b1;
                done_status <= PS_OK;
              end else begin
                state <= ISSUE;
                psen  <= 1'b1;
              end
            end
          end
          ISSUE: begin
            state <= WAIT_DONE;
            if (abort) abort_pend <= 1'b1;
          end
          WAIT_DONE: begin
            if (abort) abort_pend <= 1'b1;
            if (psdone) begin
              steps_left <= steps_dec;
              if (steps_dec == '0) begin
                state       <= IDLE;
                done_pulse  <= 1'b1;
                done_status <= PS_OK;
              end else if (abort_pend || abort) begin
                state       <= IDLE;
                done_pulse  <= 1'b1;
                done_status <= PS_ABORT;
              end else if (MIN_GAP == 0) begin
                state <= ISSUE;
                psen  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else if (tmr_tc) begin
              state       <= IDLE;
              steps_left  <= '0;
              done_pulse  <= 1'b1;
              done_status <= PS_TIMEOUT;
            end
          end
          GAP: begin
            if (abort) begin
              state       <= IDLE;
              done_pulse  <= 1'b1;
              done_status <= PS_ABORT;
            end else if (tmr_tc) begin
              state <= ISSUE;
              psen  <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Phase position: clear wins over the old value but not over this cycle's step.
  always_ff @(posedge psclk) begin
    if (!reset_n) begin
      phase_pos <= '0;
    end else begin
      phase_pos <= (pos_clear ? POS_W'(0) : phase_pos) +
                   (step_done ? (psincdec ? POS_W'(1) : {POS_W{1'b1}}) : POS_W'(0));
    end
  end

endmodule
